// File: rtl/pi_pkg.sv
// Shared constants and FSM encoding for the Leibniz pi series controller.
package pi_pkg;

    localparam int          LP_WIDTH     = 32;
    localparam logic [31:0] LP_NUMERATOR = 32'h4000_0000;
    localparam int          LP_Q_FRAC    = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_FINISH
    } state_t;

endpackage

// File: rtl/leibniz_term_ctrl_if.sv
// Request/response bundle between the series controller and its divider.
interface leibniz_term_ctrl_if
    import pi_pkg::*;
#(
    parameter int P_WIDTH = LP_WIDTH
) ();

    logic               div_start;
    logic [P_WIDTH-1:0] div_dividend;
    logic [P_WIDTH-1:0] div_divisor;
    logic [P_WIDTH-1:0] div_quotient;
    logic               div_done;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        input  div_quotient,
        input  div_done
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        output div_quotient,
        output div_done
    );

endinterface

// File: rtl/leibniz_term_ctrl.sv
// Sequences one divide per series term and accumulates the alternating
// sum of P_NUMERATOR/(2k+1) in Q4.28.
module leibniz_term_ctrl
    import pi_pkg::*;
#(
    parameter int                 P_WIDTH     = LP_WIDTH,
    parameter logic [P_WIDTH-1:0] P_NUMERATOR = P_WIDTH'(LP_NUMERATOR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [15:0]        n_terms,
    output logic               busy,
    output logic [P_WIDTH-1:0] result,
    output logic               result_valid,
    leibniz_term_ctrl_if.master div
);

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_k;
    logic [15:0]        r_n;
    logic [P_WIDTH-1:0] r_acc;
    logic [P_WIDTH-1:0] r_quot;
    logic [P_WIDTH-1:0] r_result;
    logic               r_first;
    logic [P_WIDTH-1:0] w_sum;
    logic               w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_sum  = r_k[0] ? (r_acc - r_quot) : (r_acc + r_quot);
        w_last = ((r_k + 16'd1) == r_n);
        unique case (r_state)
            S_IDLE: begin
                if (run) w_next = (n_terms == 16'd0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            // first WAIT cycle may still see the previous term's done
            S_WAIT: begin
                if (!r_first && div.div_done) w_next = S_ACCUM;
            end
            S_ACCUM:  w_next = w_last ? S_FINISH : S_ISSUE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k      <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_quot   <= '0;
            r_result <= '0;
            r_first  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_k   <= '0;
                        r_n   <= n_terms;
                        r_acc <= '0;
                        if (n_terms == 16'd0) r_result <= '0;
                    end
                end
                S_ISSUE: r_first <= 1'b1;
                S_WAIT: begin
                    r_first <= 1'b0;
                    if (!r_first && div.div_done) r_quot <= div.div_quotient;
                end
                S_ACCUM: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + 16'd1;
                    if (w_last) r_result <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign result_valid     = (r_state == S_FINISH);
    assign result           = r_result;
    assign div.div_start    = (r_state == S_ISSUE);
    assign div.div_dividend = P_NUMERATOR;
    assign div.div_divisor  = {{(P_WIDTH-17){1'b0}}, r_k, 1'b1};

endmodule

// File: tb/tb_leibniz_term_ctrl.sv
// Directed bench with a behavioural divider and result/divisor scoreboards.
module tb_leibniz_term_ctrl;
    import pi_pkg::*;

    localparam int          W   = 32;
    localparam logic [31:0] NUM = 32'h4000_0000;
    localparam int          LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [15:0]  n_terms;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result;

    leibniz_term_ctrl_if #(.P_WIDTH(W)) dif ();

    leibniz_term_ctrl #(.P_WIDTH(W), .P_NUMERATOR(NUM)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .n_terms      (n_terms),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .div          (dif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_start  = 0;
    int          n_valid  = 0;
    logic [31:0] res_q[$];
    logic [31:0] div_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] leib(input int n);
        logic [31:0] s;
        logic [31:0] q;
        s = '0;
        for (int k = 0; k < n; k++) begin
            q = NUM / 32'(2 * k + 1);
            s = (k % 2 == 1) ? s - q : s + q;
        end
        return s;
    endfunction

    // Divider model: done stays high (stale) until one cycle after start.
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dif.div_done     <= 1'b0;
            dif.div_quotient <= '0;
            m_cnt            <= 0;
        end else if (dif.div_start) begin
            m_a   <= dif.div_dividend;
            m_b   <= dif.div_divisor;
            m_cnt <= LAT;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == LAT) dif.div_done <= 1'b0;
            if (m_cnt == 1) begin
                dif.div_done     <= 1'b1;
                dif.div_quotient <= m_a / m_b;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (dif.div_start) begin
                n_start++;
                if (div_q.size() == 0)
                    check("spurious_start", 32'(div_q.size()), 32'd1);
                else
                    check("divisor", dif.div_divisor, div_q.pop_front());
                check("dividend", dif.div_dividend, NUM);
            end
            if (result_valid) begin
                n_valid++;
                check("busy_at_valid", 32'(busy), 32'd1);
                if (res_q.size() == 0)
                    check("spurious_valid", 32'(res_q.size()), 32'd1);
                else
                    check("result", result, res_q.pop_front());
            end
        end
    end

    task automatic start_run(input int n);
        @(negedge clk);
        run     = 1'b1;
        n_terms = 16'(n);
        res_q.push_back(leib(n));
        for (int k = 0; k < n; k++) div_q.push_back(32'(2 * k + 1));
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_valid(input int target, input string tag);
        int cyc;
        cyc = 0;
        while (n_valid < target && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check(tag, 32'(n_valid), 32'(target));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_start"}, 32'(dif.div_start), 32'd0);
        check({tag, "_divisor"}, dif.div_divisor, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int v;
        int cyc;
        rst     = 1'b1;
        run     = 1'b0;
        n_terms = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;

        // n=1
        start_run(1);
        check("busy_n1", 32'(busy), 32'd1);
        wait_valid(1, "valid_n1");
        repeat (3) @(negedge clk);
        #1;
        check("hold_n1", result, 32'h4000_0000);
        check("idle_busy_n1", 32'(busy), 32'd0);
        check("starts_n1", 32'(n_start), 32'd1);

        // n=3
        s = n_start;
        start_run(3);
        wait_valid(2, "valid_n3");
        check("result_n3_const", result, 32'h3777_7777);
        check("starts_n3", 32'(n_start - s), 32'd3);

        // n=2
        start_run(2);
        wait_valid(3, "valid_n2");
        check("result_n2_const", result, 32'h2AAA_AAAB);

        // n=0
        s = n_start;
        @(negedge clk);
        run     = 1'b1;
        n_terms = 16'd0;
        res_q.push_back(32'd0);
        @(negedge clk);
        run = 1'b0;
        #1;
        check("zero_valid", 32'(result_valid), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_result", result, 32'd0);
        @(negedge clk);
        #1;
        check("zero_valid_off", 32'(result_valid), 32'd0);
        check("zero_busy_off", 32'(busy), 32'd0);
        check("zero_starts", 32'(n_start - s), 32'd0);

        // run pulsed mid-flight must be ignored
        s = n_start;
        v = n_valid;
        start_run(3);
        repeat (3) @(negedge clk);
        run     = 1'b1;
        n_terms = 16'd5;
        @(negedge clk);
        run = 1'b0;
        wait_valid(v + 1, "valid_rerun");
        repeat (15) @(negedge clk);
        #1;
        check("starts_rerun", 32'(n_start - s), 32'd3);
        check("valids_rerun", 32'(n_valid - v), 32'd1);

        // reset during the second term's WAIT
        s = n_start;
        v = n_valid;
        @(negedge clk);
        run     = 1'b1;
        n_terms = 16'd3;
        div_q.push_back(32'd1);
        div_q.push_back(32'd3);
        @(negedge clk);
        run = 1'b0;
        cyc = 0;
        while (n_start < s + 2 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("reach_term2", 32'(n_start - s), 32'd2);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_valid", 32'(n_valid - v), 32'd0);
        check("midrst_div_q", 32'(div_q.size()), 32'd0);
        start_run(1);
        wait_valid(v + 1, "valid_after_rst");
        check("result_after_rst", result, 32'h4000_0000);
        check("res_q_empty", 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
